// File: rtl/iob_timer_master_pkg.sv
// Shared definitions for the timer bus initiator: timer register map,
// FSM state encoding (visible to benches for probing) and request payload helpers.
package iob_timer_master_pkg;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 64;

    // Timer register map
    localparam logic [ADDR_W-1:0] TIMER_RESET     = 2'd0;
    localparam logic [ADDR_W-1:0] TIMER_STOP      = 2'd1;
    localparam logic [ADDR_W-1:0] TIMER_DATA_HIGH = 2'd2;
    localparam logic [ADDR_W-1:0] TIMER_DATA_LOW  = 2'd3;

    // Initiator FSM state encoding
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST_REQ   = 4'd1,
        ST_RST_WAIT  = 4'd2,
        ST_RUN       = 4'd3,
        ST_STOP_REQ  = 4'd4,
        ST_STOP_WAIT = 4'd5,
        ST_HI_REQ    = 4'd6,
        ST_HI_WAIT   = 4'd7,
        ST_LO_REQ    = 4'd8,
        ST_LO_WAIT   = 4'd9,
        ST_DONE      = 4'd10
    } state_e;

    // Bus request payload driven alongside valid
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // True for the single-cycle request states
    function automatic logic is_req_state(state_e s);
        return (s inside {ST_RST_REQ, ST_STOP_REQ, ST_HI_REQ, ST_LO_REQ});
    endfunction

    // True for the states waiting on the timer acknowledge
    function automatic logic is_wait_state(state_e s);
        return (s inside {ST_RST_WAIT, ST_STOP_WAIT, ST_HI_WAIT, ST_LO_WAIT});
    endfunction

    // Address/write data carried by each request state
    function automatic bus_req_t req_payload(state_e s);
        bus_req_t r;
        r.wdata = '0;
        case (s)
            ST_RST_REQ: begin
                r.address = TIMER_RESET;
                r.wdata   = DATA_W'(1);
            end
            ST_STOP_REQ: r.address = TIMER_STOP;
            ST_HI_REQ:   r.address = TIMER_DATA_HIGH;
            ST_LO_REQ:   r.address = TIMER_DATA_LOW;
            default:     r.address = TIMER_RESET;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/iob_timer_master.sv
// Bus initiator for the timer peripheral: turns start/stop pulses into
// reset, stop/latch, read-high, read-low transactions and presents the
// 64-bit elapsed count with a done pulse.
// Optional feature: define TIMER_MASTER_TIMEOUT_EN to abort a transaction
// whose ready does not arrive within TIMEOUT_CYCLES cycles (error pulse).
module iob_timer_master
    import iob_timer_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic               error,
    output logic               valid,
    output logic [ADDR_W-1:0]  address,
    output logic [DATA_W-1:0]  wdata,
    input  logic [DATA_W-1:0]  rdata,
    input  logic               ready
);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    bus_req_t           req;

`ifdef TIMER_MASTER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout;

    // Cycles spent in the current wait state; cleared while requesting
    always_comb begin
        wait_cnt_d = '0;
        if (is_wait_state(state_q)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Last allowed wait cycle passed without an acknowledge
    assign timeout = is_wait_state(state_q) && !ready && (wait_cnt_q == WAIT_LAST);

    // Wait counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // Next state, captured data and next registered outputs
    always_comb begin
        state_d = state_q;
        error_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        hi_d    = hi_q;
        req     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RST_REQ;
            end
            ST_RST_REQ:  state_d = ST_RST_WAIT;
            ST_RST_WAIT: begin
                if (ready) state_d = ST_RUN;
            end
            ST_RUN: begin
                // stop has priority over a simultaneous restart
                if (stop) begin
                    state_d = ST_STOP_REQ;
                end else if (start) begin
                    state_d = ST_RST_REQ;
                end
            end
            ST_STOP_REQ:  state_d = ST_STOP_WAIT;
            ST_STOP_WAIT: begin
                if (ready) state_d = ST_HI_REQ;
            end
            ST_HI_REQ:    state_d = ST_HI_WAIT;
            ST_HI_WAIT: begin
                if (ready) begin
                    hi_d    = rdata;
                    state_d = ST_LO_REQ;
                end
            end
            ST_LO_REQ:    state_d = ST_LO_WAIT;
            ST_LO_WAIT: begin
                if (ready) begin
                    // both halves land in count on the same edge
                    count_d = {hi_q, rdata};
                    state_d = ST_DONE;
                end
            end
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

`ifdef TIMER_MASTER_TIMEOUT_EN
        if (timeout) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
        end
`endif

        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        valid_d = is_req_state(state_d);

        // Payload changes only when a request is issued, then holds
        if (valid_d) begin
            req     = req_payload(state_d);
            addr_d  = req.address;
            wdata_d = req.wdata;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            hi_q    <= hi_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign valid   = valid_q;
    assign address = addr_q;
    assign wdata   = wdata_q;
    assign count   = count_q;

endmodule

// File: tb/tb_iob_timer_master.sv
// Bench for iob_timer_master: a behavioural timer responder, a timeline
// model of expected bus/handshake outputs, and a per-cycle compare process.
module tb_iob_timer_master;
    import iob_timer_master_pkg::*;

    localparam int NC  = 1024;
    localparam int INF = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy, done, error, valid, ready;
    logic [63:0] count;
    logic [1:0]  address;
    logic [31:0] wdata, rdata;

    iob_timer_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .busy(busy), .done(done), .count(count), .error(error),
        .valid(valid), .address(address), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- timer responder ----------------
    logic [63:0] preload = 64'd0;
    bit          ready_block = 1'b0;
    logic [63:0] t_cnt, t_latched;
    logic        t_rst_pend;
    logic [1:0]  t_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready      <= 1'b0;
            t_addr     <= 2'd0;
            t_rst_pend <= 1'b0;
            t_cnt      <= 64'd0;
            t_latched  <= 64'd0;
        end else begin
            ready      <= valid && !ready_block;
            t_addr     <= address;
            t_rst_pend <= valid && (address == TIMER_RESET) && wdata[0];
            t_cnt      <= t_rst_pend ? preload : t_cnt + 64'd1;
            if (valid && address == TIMER_STOP) t_latched <= t_cnt;
        end
    end

    assign rdata = !ready ? 32'hDEAD_BEEF :
                   (t_addr == TIMER_DATA_HIGH) ? t_latched[63:32] :
                   (t_addr == TIMER_DATA_LOW)  ? t_latched[31:0]  : 32'd0;

    // ---------------- expected-behaviour model ----------------
    bit          m_valid   [NC];
    logic [1:0]  m_addr    [NC];
    logic [31:0] m_wdata   [NC];
    bit          m_done    [NC];
    bit          m_err     [NC];
    bit          m_cnt_upd [NC];
    logic [63:0] m_cnt_val [NC];
    bit          m_active = 0, m_meas = 0;
    int          m_run_from = INF, m_idle_from = INF, m_busy_from = INF, m_busy_to = -1, m_rst_c = 0;
    logic [63:0] m_rst_pre = 64'd0;

    function automatic bit m_is_idle(int c);
        return !m_active || c >= m_idle_from;
    endfunction

    task automatic m_req(int c, logic [1:0] a, logic [31:0] d);
        m_valid[c] = 1'b1; m_addr[c] = a; m_wdata[c] = d;
    endtask

    task automatic m_start_txn(int c);
        if (m_is_idle(c)) m_busy_from = c + 1;
        m_active = 1; m_meas = 0; m_run_from = c + 3;
        m_idle_from = INF; m_busy_to = INF; m_rst_c = c; m_rst_pre = preload;
        m_req(c + 1, TIMER_RESET, 32'd1);
    endtask

    task automatic m_stop_txn(int k);
        m_meas = 1; m_busy_to = k + 6; m_idle_from = k + 8;
        m_req(k + 1, TIMER_STOP, 32'd0);
        m_req(k + 3, TIMER_DATA_HIGH, 32'd0);
        m_req(k + 5, TIMER_DATA_LOW, 32'd0);
        m_done[k + 7] = 1'b1;
        m_cnt_upd[k + 7] = 1'b1;
        m_cnt_val[k + 7] = m_rst_pre + 64'(k - m_rst_c - 2);
    endtask

    task automatic m_accept(int c, bit st, bit sp);
        if (m_is_idle(c)) begin
            if (st) m_start_txn(c);
        end else if (!m_meas && c >= m_run_from) begin
            if (sp) m_stop_txn(c);
            else if (st) m_start_txn(c);
        end
    endtask

    task automatic m_timeout(int c);
        m_run_from = INF; m_busy_to = c + 17; m_idle_from = c + 18;
        m_err[c + 18] = 1'b1;
    endtask

    task automatic m_reset(int c);
        for (int i = c; i < NC; i++) begin
            m_valid[i] = 0; m_done[i] = 0; m_err[i] = 0; m_cnt_upd[i] = 0;
        end
        m_active = 0; m_meas = 0; m_busy_from = INF; m_busy_to = -1;
    endtask

    // ---------------- checking ----------------
    int n_checks = 0, n_pass = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, got, want);
    endtask

    logic [63:0] cur_cnt = 64'd0;
    logic        prev_valid = 1'b0;
    int          last_done_c = -1, last_rst_c = -1, last_err_c = -1, n_done = 0;
    logic [31:0] last_rst_wdata = 32'd0;

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_cnt = 64'd0;
            prev_valid = 1'b0;
        end else if (cyc < NC) begin
            if (m_cnt_upd[cyc]) cur_cnt = m_cnt_val[cyc];
            chk("valid", 64'(valid), 64'(m_valid[cyc]));
            chk("busy", 64'(busy), 64'(cyc >= m_busy_from && cyc <= m_busy_to));
            chk("done", 64'(done), 64'(m_done[cyc]));
            chk("error", 64'(error), 64'(m_err[cyc]));
            chk("count", count, cur_cnt);
            chk("valid_b2b", 64'(valid & prev_valid), 64'd0);
            if (m_valid[cyc]) begin
                chk("req_addr", 64'(address), 64'(m_addr[cyc]));
                chk("req_wdata", 64'(wdata), 64'(m_wdata[cyc]));
            end else if (cyc > 0 && m_valid[cyc - 1]) begin
                chk("ack_addr", 64'(address), 64'(m_addr[cyc - 1]));
                chk("ack_wdata", 64'(wdata), 64'(m_wdata[cyc - 1]));
            end
            if (done) begin last_done_c = cyc; n_done++; end
            if (error) last_err_c = cyc;
            if (valid && address == TIMER_RESET) begin
                last_rst_c = cyc; last_rst_wdata = wdata;
            end
            prev_valid = valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic pulse(bit st, bit sp);
        start = st; stop = sp;
        m_accept(cyc, st, sp);
        step();
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    int t0, nd;

    initial begin
        #12;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_err", 64'({done, error}), 64'd0);
        chk("rst_count", count, 64'd0);
        chk("rst_bus", 64'({address, wdata}), 64'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Basic measurement
        t0 = cyc;
        pulse(1, 0); idle(99);
        pulse(0, 1); idle(12);
        chk("basic_count", count, 64'd98);
        chk("basic_done_cycle", 64'(last_done_c - t0), 64'd107);
        chk("reset_wdata", 64'(last_rst_wdata), 64'd1);

        // Ignored pulses: stop in IDLE, start during STOP_WAIT
        pulse(0, 1); idle(5);
        nd = n_done;
        t0 = cyc;
        pulse(1, 0); idle(19);
        pulse(0, 1); idle(1);
        pulse(1, 0); idle(10);
        chk("ignore_count", count, 64'd18);
        chk("ignore_one_done", 64'(n_done - nd), 64'd1);

        // Restart while running
        t0 = cyc;
        pulse(1, 0); idle(49);
        pulse(1, 0); idle(99);
        pulse(0, 1); idle(12);
        chk("restart_rst_cycle", 64'(last_rst_c - t0), 64'd51);
        chk("restart_count", count, 64'd98);
        chk("restart_done_cycle", 64'(last_done_c - t0), 64'd157);

        // High word path: soft reset preloads a value near a 32-bit carry
        preload = 64'h0000_0001_FFFF_FFF0;
        pulse(1, 0); idle(99);
        pulse(0, 1); idle(12);
        chk("preload_count", count, 64'h0000_0002_0000_0052);
        preload = 64'd0;

        // Reset during HI_WAIT
        pulse(1, 0); idle(19);
        pulse(0, 1); idle(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({valid, busy, done, error}), 64'd0);
        chk("midrst_count", count, 64'd0);
        chk("midrst_bus", 64'({address, wdata}), 64'd0);
        m_reset(cyc);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        t0 = cyc;
        pulse(1, 0); idle(39);
        pulse(0, 1); idle(12);
        chk("after_rst_count", count, 64'd38);
        chk("after_rst_done_cycle", 64'(last_done_c - t0), 64'd47);

`ifdef TIMER_MASTER_TIMEOUT_EN
        // Responder that never acknowledges
        ready_block = 1'b1;
        t0 = cyc;
        pulse(1, 0);
        m_timeout(t0);
        idle(25);
        ready_block = 1'b0;
        chk("timeout_err_cycle", 64'(last_err_c - t0), 64'd18);
        chk("timeout_count_kept", count, 64'd38);
        idle(2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
